// File: rtl/edge_pkg.sv
// Shared types for the streaming Sobel edge engine.
// No logic of its own; enums and helpers used by edge_stream and sobel_kernel.
// Not applicable.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_MAG  = 2'b01,
        MODE_THR  = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // Signed gradient width: 1-2-1 kernels grow by at most 4x, plus a sign bit.
    function automatic int grad_w(input int pix_w);
        return pix_w + 4;
    endfunction

    // Encoding 11 is not a distinct mode; it behaves as magnitude.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_PASS;
            2'b10:   return MODE_THR;
            default: return MODE_MAG;
        endcase
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// 3x3 Sobel gradient, |gx|+|gy| magnitude and output mode select; no border handling.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module sobel_kernel
    import edge_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [8:0][PIX_W-1:0] win_i,   // [0] top-left .. [8] bottom-right, row-major
    input  mode_t                 mode_i,
    input  logic [PIX_W-1:0]      thr_i,
    output logic [PIX_W-1:0]      pix_o
);

    localparam int GW = grad_w(PIX_W);
    localparam logic [GW-1:0] PIX_MAX = {{(GW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    logic signed [GW-1:0] px [9];
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [GW-1:0]        abs_x;
    logic [GW-1:0]        abs_y;
    logic [GW-1:0]        sum;
    logic [GW-1:0]        half;
    logic [PIX_W-1:0]     mag;

    // Zero-extend each window pixel into the signed gradient width.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            px[i] = $signed({{(GW-PIX_W){1'b0}}, win_i[i]});
        end
    end

    // Gradients (right minus left, bottom minus top), clamped half-sum magnitude, mode select.
    always_comb begin
        gx    = (px[2] + px[5] + px[5] + px[8]) - (px[0] + px[3] + px[3] + px[6]);
        gy    = (px[6] + px[7] + px[7] + px[8]) - (px[0] + px[1] + px[1] + px[2]);
        abs_x = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_y = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        sum   = abs_x + abs_y;
        half  = sum >> 1;
        mag   = (half > PIX_MAX) ? {PIX_W{1'b1}} : half[PIX_W-1:0];
        case (mode_i)
            MODE_PASS: pix_o = win_i[4];
            MODE_THR:  pix_o = (mag > thr_i) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            default:   pix_o = mag;
        endcase
    end

endmodule

// File: rtl/edge_stream.sv
// Streaming 3x3 Sobel engine: one output pixel per input pixel, FIFO in, FIFO out, back-to-back frames.
// Latency: output k is pushed in the cycle that pops input k+W+1; the last W+1 outputs drain in FLUSH.
// Backpressure: upstream empty or downstream full stalls the whole pipe; nothing is dropped.
module edge_stream
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int PIX_W      = 8,
    parameter int REG_SIZE   = 2*IMG_WIDTH+3,
    parameter int FCNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_empty,
    input  logic [PIX_W-1:0]  in_dout,
    output logic              in_rd_en,
    input  logic              out_full,
    output logic              out_wr_en,
    output logic [PIX_W-1:0]  out_din,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  threshold,
    output logic              done,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int W     = IMG_WIDTH;

    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NPIX - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    mode_t               mode_q, mode_d;
    logic [PIX_W-1:0]    thr_q, thr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                en_q;
    logic                shift_en;
    logic                emit;

    // The register holds the REG_SIZE-1 most recent pixels; the window view appends the
    // pixel being consumed this cycle as entry 0, so the centre view[W+1] is output k.
    logic [REG_SIZE-2:0][PIX_W-1:0] shift_q;
    logic [REG_SIZE-1:0][PIX_W-1:0] view;
    logic [PIX_W-1:0]               incoming;
    logic [8:0][PIX_W-1:0]          win;
    logic [PIX_W-1:0]               kern_pix;
    logic                           border;

    assign incoming = (state_q == S_FLUSH) ? {PIX_W{1'b0}} : in_dout;
    assign view     = {shift_q, incoming};
    assign win      = {view[0],     view[1],     view[2],
                       view[W],     view[W+1],   view[W+2],
                       view[2*W],   view[2*W+1], view[2*W+2]};

    sobel_kernel #(
        .PIX_W (PIX_W)
    ) u_kernel (
        .win_i  (win),
        .mode_i (mode_q),
        .thr_i  (thr_q),
        .pix_o  (kern_pix)
    );

    assign border      = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
    assign out_din     = (border && mode_q != MODE_PASS) ? {PIX_W{1'b0}} : kern_pix;
    assign frame_count = fcnt_q;

    // Next-state, handshakes and counter updates for FILL/RUN/FLUSH/DONE.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        fcnt_d    = fcnt_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        done      = 1'b0;
        shift_en  = 1'b0;
        emit      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (en_q && !in_empty) begin
                    in_rd_en = 1'b1;
                    shift_en = 1'b1;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == '0) begin
                        mode_d = decode_mode(mode);
                        thr_d  = threshold;
                    end
                    if (in_cnt_q == LAST_FILL) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (en_q && !in_empty && !out_full) begin
                    in_rd_en  = 1'b1;
                    out_wr_en = 1'b1;
                    shift_en  = 1'b1;
                    emit      = 1'b1;
                    in_cnt_d  = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == LAST_PIX) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (en_q && !out_full) begin
                    out_wr_en = 1'b1;
                    shift_en  = 1'b1;
                    emit      = 1'b1;
                    if (out_cnt_q == LAST_PIX) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                fcnt_d    = fcnt_q + FCNT_W'(1);
                in_cnt_d  = '0;
                out_cnt_d = '0;
                row_d     = '0;
                col_d     = '0;
                state_d   = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
        if (emit) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Control state; en_q keeps both handshakes low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FILL;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            mode_q    <= MODE_PASS;
            thr_q     <= '0;
            fcnt_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
            fcnt_q    <= fcnt_d;
            en_q      <= 1'b1;
        end
    end

    // Window shift: every pop (or flush step) moves each entry up one place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= view[REG_SIZE-2:0];
        end
    end

endmodule

// File: tb/tb_edge_stream.sv
// Self-checking bench for edge_stream on a 4x4 image: spec vectors, ramp pass-through, random model check.
// Inputs driven on the falling edge, outputs sampled 1ns later, away from the rising edge.
// Random empty/full gaps exercise stalls on both sides.
module tb_edge_stream;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clock;
    logic        reset;
    logic        in_empty;
    logic [7:0]  in_dout;
    logic        in_rd_en;
    logic        out_full;
    logic        out_wr_en;
    logic [7:0]  out_din;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic        done;
    logic [15:0] frame_count;

    logic        in_rd_en_b;
    logic        out_wr_en_b;
    logic [7:0]  out_din_b;
    logic        done_b;
    logic [1:0]  frame_count_b;

    edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .FCNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din), .mode(mode),
        .threshold(threshold), .done(done), .frame_count(frame_count)
    );

    edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .FCNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en_b),
        .out_full(out_full), .out_wr_en(out_wr_en_b), .out_din(out_din_b), .mode(mode),
        .threshold(threshold), .done(done_b), .frame_count(frame_count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         pat;      // 0 flat 100, 1 vertical step 0|20
        logic [1:0] md;
        logic [7:0] thr;
        int         exp_int;  // expected value of every interior pixel
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_fc = 0;
    logic [7:0] in_q [$];
    logic [1:0] md_q [$];
    logic [7:0] thr_q [$];
    int         exp_q [$];
    vec_t       vecs [7];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic clear_queues();
        in_q.delete();
        md_q.delete();
        thr_q.delete();
        exp_q.delete();
    endtask

    // Reference: Sobel computed straight from the image with signed kernel weights.
    function automatic void model_frame(input int base, input int md, input int thr);
        int k, v, gx, gy, p, mag;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                k = r * W + c;
                if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
                    v = (md == 0) ? int'(in_q[base+k]) : 0;
                end else begin
                    gx = 0;
                    gy = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            p  = int'(in_q[base + (r+dr)*W + (c+dc)]);
                            gx += dc * ((dr == 0) ? 2 : 1) * p;
                            gy += dr * ((dc == 0) ? 2 : 1) * p;
                        end
                    end
                    mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
                    if (mag > 255) mag = 255;
                    case (md)
                        0:       v = int'(in_q[base+k]);
                        2:       v = (mag > thr) ? 255 : 0;
                        default: v = mag;
                    endcase
                end
                exp_q.push_back(v);
            end
        end
    endfunction

    task automatic add_random_frame();
        int base;
        logic [1:0] md;
        logic [7:0] thr;
        base = in_q.size();
        md   = 2'($urandom);
        thr  = 8'($urandom);
        for (int k = 0; k < NPIX; k++) begin
            if ($urandom_range(1) == 1) in_q.push_back(($urandom_range(1) == 1) ? 8'd255 : 8'd0);
            else                        in_q.push_back(8'($urandom));
        end
        md_q.push_back(md);
        thr_q.push_back(thr);
        model_frame(base, int'(md), int'(thr));
    endtask

    task automatic load_table(input vec_t v);
        int r, c;
        clear_queues();
        for (int k = 0; k < NPIX; k++) begin
            r = k / W;
            c = k % W;
            if (v.pat == 0) in_q.push_back(8'd100);
            else            in_q.push_back((c >= 2) ? 8'd20 : 8'd0);
            exp_q.push_back((r == 0 || r == H-1 || c == 0 || c == W-1) ? 0 : v.exp_int);
        end
        md_q.push_back(v.md);
        thr_q.push_back(v.thr);
    endtask

    // Upstream FWFT FIFO + downstream FIFO model. mode/threshold carry the frame's value only on the
    // cycle that can pop a frame's first pixel, and junk otherwise, so latching is exercised.
    task automatic run_stream(input int p_empty, input int full_mode, input int stop_pops, input int max_cyc);
        int pop_idx, got, cyc, tail, dones, f;
        bit fin;
        pop_idx = 0; got = 0; cyc = 0; tail = 0; dones = 0; fin = 0;
        while (!fin) begin
            @(negedge clock);
            in_empty = (pop_idx >= in_q.size()) || ($urandom_range(99) < p_empty);
            in_dout  = (pop_idx < in_q.size()) ? in_q[pop_idx] : 8'($urandom);
            if (pop_idx < in_q.size() && (pop_idx % NPIX) == 0) begin
                f         = pop_idx / NPIX;
                mode      = md_q[f];
                threshold = thr_q[f];
            end else begin
                mode      = 2'($urandom);
                threshold = 8'($urandom);
            end
            case (full_mode)
                1:       out_full = cyc[0];
                2:       out_full = ($urandom_range(99) < 30);
                default: out_full = 1'b0;
            endcase
            #1;
            check("handshake", {30'd0, in_rd_en & in_empty, out_wr_en & out_full}, 0);
            if (in_rd_en && !in_empty) pop_idx++;
            if (out_wr_en && !out_full) begin
                if (stop_pops == 0 && got < exp_q.size())
                    check($sformatf("pix%0d", got), int'(out_din), exp_q[got]);
                got++;
            end
            if (done) dones++;
            cyc++;
            if (stop_pops > 0) begin
                fin = (pop_idx >= stop_pops) || (cyc >= max_cyc);
            end else begin
                if (got >= exp_q.size()) tail++;
                fin = (tail >= 4) || (cyc >= max_cyc);
            end
        end
        if (stop_pops == 0) begin
            check("out_count", got, exp_q.size());
            check("done_pulses", dones, in_q.size() / NPIX);
        end else begin
            check("partial_pops", pop_idx, stop_pops);
        end
    endtask

    task automatic check_fc(input string tag);
        check({tag, "_fcnt"}, int'(frame_count), exp_fc & 16'hFFFF);
        check({tag, "_fcnt_w2"}, int'(frame_count_b), exp_fc % 4);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_fc = 0;
    endtask

    initial begin
        vecs[0] = '{0, 2'b01, 8'd0,  0};
        vecs[1] = '{1, 2'b01, 8'd0,  40};
        vecs[2] = '{1, 2'b10, 8'd30, 255};
        vecs[3] = '{1, 2'b10, 8'd40, 0};
        vecs[4] = '{1, 2'b10, 8'd39, 255};
        vecs[5] = '{1, 2'b11, 8'd0,  40};
        vecs[6] = '{0, 2'b10, 8'd0,  0};

        reset = 1'b0; in_empty = 1'b0; in_dout = 8'd7; out_full = 1'b0; mode = 2'b01; threshold = 8'd0;

        // Reset state: no handshakes even with data available.
        repeat (3) @(negedge clock);
        #1;
        check("rst_rd_en", int'(in_rd_en), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        check("rst_done", int'(done), 0);
        check_fc("rst");
        @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b1;
        @(negedge clock);
        #1;
        check("idle_rd_en", int'(in_rd_en), 0);

        // Spec vectors: flat, step in magnitude and threshold modes, mode 11 alias.
        foreach (vecs[i]) begin
            load_table(vecs[i]);
            run_stream(0, 0, 0, 500);
            exp_fc++;
            check_fc($sformatf("vec%0d", i));
        end

        // Pass mode ramp under toggling full and random empty.
        clear_queues();
        for (int k = 0; k < NPIX; k++) begin
            in_q.push_back(8'(k));
            exp_q.push_back(k);
        end
        md_q.push_back(2'b00);
        thr_q.push_back(8'd0);
        run_stream(30, 1, 0, 1000);
        exp_fc++;
        check_fc("ramp");

        // Random frames back-to-back against the reference model.
        clear_queues();
        for (int f = 0; f < 6; f++) add_random_frame();
        run_stream(30, 2, 0, 3000);
        exp_fc += 6;
        check_fc("random");

        // Reset after 7 pixels: partial frame discarded, next pop is pixel (0,0).
        clear_queues();
        add_random_frame();
        run_stream(0, 0, 7, 200);
        @(negedge clock);
        reset    = 1'b0;
        in_empty = 1'b0;
        #1;
        check("midrst_rd_en", int'(in_rd_en), 0);
        check("midrst_wr_en", int'(out_wr_en), 0);
        exp_fc = 0;
        check_fc("midrst");
        @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b1;
        clear_queues();
        add_random_frame();
        run_stream(20, 2, 0, 1000);
        exp_fc = 1;
        check_fc("after_rst");

        // Three frames with upstream never empty, then two more to wrap the 2-bit counter.
        do_reset();
        clear_queues();
        for (int f = 0; f < 3; f++) add_random_frame();
        run_stream(0, 0, 0, 1000);
        exp_fc = 3;
        check_fc("b2b3");
        clear_queues();
        for (int f = 0; f < 2; f++) add_random_frame();
        run_stream(0, 0, 0, 1000);
        exp_fc = 5;
        check_fc("b2b5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
